// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard/stall requests coming from the datapath
// stages and the stall/flush/redirect controls going back to them.
interface pipeline_ctrl_if;
  logic       i_stall_req;
  logic       d_stall_req;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_uses_rs;
  logic       d_uses_rt;
  logic       e_memread;
  logic [4:0] e_wreg;
  logic       e_mdu_start;
  logic       e_mdu_div;
  logic       m_exception;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic       flush_w;
  logic       redirect_valid;
  logic       mdu_busy;

  // Datapath side: raises requests, obeys controls
  modport master (
    output i_stall_req, d_stall_req, d_rs, d_rt, d_uses_rs, d_uses_rt,
           e_memread, e_wreg, e_mdu_start, e_mdu_div, m_exception,
    input  stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, redirect_valid, mdu_busy
  );

  // Controller side
  modport slave (
    input  i_stall_req, d_stall_req, d_rs, d_rt, d_uses_rs, d_uses_rt,
           e_memread, e_wreg, e_mdu_start, e_mdu_div, m_exception,
    output stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w, redirect_valid, mdu_busy
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller. Resolves exception, data-memory
// wait, multiply/divide occupancy, load-use and fetch-wait causes in fixed
// priority order, and sequences multi-cycle MDU ops in E with a small FSM.
// MULT_CYCLES and DIV_CYCLES are expected to lie in 2..65 (6-bit counter).
module pipeline_ctrl #(
  parameter int MULT_CYCLES = 3,
  parameter int DIV_CYCLES  = 32
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_DONE
  } mdu_state_t;

  // The start cycle and the final counter==0 cycle both stall E, hence N-2
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 2);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 2);

  mdu_state_t state, state_next;
  logic [5:0] count, count_next;
  logic       mdu_hold;
  logic       load_use;

  assign mdu_hold = ((state == MDU_IDLE) && bus.e_mdu_start) || (state == MDU_BUSY);

  assign load_use = bus.e_memread && (bus.e_wreg != 5'd0) &&
                    ((bus.d_uses_rs && (bus.d_rs == bus.e_wreg)) ||
                     (bus.d_uses_rt && (bus.d_rt == bus.e_wreg)));

  // MDU state and counter register; reset always leaves the unit idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
      count <= 6'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // MDU sequencing: exceptions abort, data-memory waits freeze progress
  always_comb begin
    state_next = state;
    count_next = count;
    if (bus.m_exception) begin
      state_next = MDU_IDLE;
      count_next = 6'd0;
    end else if (!bus.d_stall_req) begin
      case (state)
        MDU_IDLE: begin
          if (bus.e_mdu_start) begin
            state_next = MDU_BUSY;
            count_next = bus.e_mdu_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MDU_BUSY: begin
          if (count == 6'd0) begin
            state_next = MDU_DONE;
          end else begin
            count_next = count - 6'd1;
          end
        end
        MDU_DONE: begin
          state_next = MDU_IDLE;
        end
        default: begin
          state_next = MDU_IDLE;
          count_next = 6'd0;
        end
      endcase
    end
  end

  // Stall/flush decode: only the highest-priority active cause drives outputs
  always_comb begin
    bus.stall_f        = 1'b0;
    bus.stall_d        = 1'b0;
    bus.stall_e        = 1'b0;
    bus.stall_m        = 1'b0;
    bus.flush_d        = 1'b0;
    bus.flush_e        = 1'b0;
    bus.flush_m        = 1'b0;
    bus.flush_w        = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.mdu_busy       = 1'b0;
    if (reset) begin
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
      bus.flush_m = 1'b1;
      bus.flush_w = 1'b1;
    end else begin
      bus.mdu_busy = (state == MDU_BUSY) || (state == MDU_DONE);
      if (bus.m_exception) begin
        bus.flush_d        = 1'b1;
        bus.flush_e        = 1'b1;
        bus.flush_m        = 1'b1;
        bus.redirect_valid = 1'b1;
      end else if (bus.d_stall_req) begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.stall_e = 1'b1;
        bus.stall_m = 1'b1;
        bus.flush_w = 1'b1;
      end else if (mdu_hold) begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.stall_e = 1'b1;
        bus.flush_m = 1'b1;
      end else if (load_use) begin
        bus.stall_f = 1'b1;
        bus.stall_d = 1'b1;
        bus.flush_e = 1'b1;
      end else if (bus.i_stall_req) begin
        bus.stall_f = 1'b1;
        bus.flush_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a reference model predicts the
// output vector for every driven cycle; predictions are queued and compared
// when the outputs are sampled.
module tb_pipeline_ctrl;

  localparam int MULT_N = 3;
  localparam int DIV_N  = 32;

  typedef struct {
    logic       rst;
    logic       istall;
    logic       dstall;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       memread;
    logic [4:0] wreg;
    logic       start;
    logic       div;
    logic       exc;
  } stim_t;

  logic clk;
  logic reset;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_e_count = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_out;

  // Reference MDU model: phase 0 idle, 1 busy, 2 done; left = busy cycles remaining
  int ref_phase = 0;
  int ref_left  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 0; s.istall = 0; s.dstall = 0; s.rs = 0; s.rt = 0; s.urs = 0;
    s.urt = 0; s.memread = 0; s.wreg = 0; s.start = 0; s.div = 0; s.exc = 0;
    return s;
  endfunction

  // Output order: stall_f,d,e,m, flush_d,e,m,w, redirect_valid, mdu_busy
  function automatic logic [9:0] modelOut(stim_t s);
    logic [9:0] o;
    logic lu;
    logic hold;
    o = '0;
    lu = s.memread && (s.wreg != 0) &&
         ((s.urs && s.rs == s.wreg) || (s.urt && s.rt == s.wreg));
    hold = (ref_phase == 0 && s.start) || ref_phase == 1;
    if (s.rst) begin
      o[5] = 1; o[4] = 1; o[3] = 1; o[2] = 1;
    end else begin
      o[0] = (ref_phase != 0);
      if (s.exc) begin
        o[5] = 1; o[4] = 1; o[3] = 1; o[1] = 1;
      end else if (s.dstall) begin
        o[9] = 1; o[8] = 1; o[7] = 1; o[6] = 1; o[2] = 1;
      end else if (hold) begin
        o[9] = 1; o[8] = 1; o[7] = 1; o[3] = 1;
      end else if (lu) begin
        o[9] = 1; o[8] = 1; o[4] = 1;
      end else if (s.istall) begin
        o[9] = 1; o[5] = 1;
      end
    end
    return o;
  endfunction

  task automatic modelAdvance(stim_t s);
    if (s.rst || s.exc) begin
      ref_phase = 0;
      ref_left  = 0;
    end else if (!s.dstall) begin
      case (ref_phase)
        0: if (s.start) begin
             ref_left  = (s.div ? DIV_N : MULT_N) - 1;
             ref_phase = 1;
           end
        1: begin
             ref_left--;
             if (ref_left == 0) ref_phase = 2;
           end
        default: ref_phase = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input string tag, input stim_t s);
    logic [9:0] got;
    @(negedge clk);
    reset               = s.rst;
    bus.i_stall_req     = s.istall;
    bus.d_stall_req     = s.dstall;
    bus.d_rs            = s.rs;
    bus.d_rt            = s.rt;
    bus.d_uses_rs       = s.urs;
    bus.d_uses_rt       = s.urt;
    bus.e_memread       = s.memread;
    bus.e_wreg          = s.wreg;
    bus.e_mdu_start     = s.start;
    bus.e_mdu_div       = s.div;
    bus.m_exception     = s.exc;
    exp_q.push_back(modelOut(s));
    #2;
    got = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
           bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w,
           bus.redirect_valid, bus.mdu_busy};
    last_out = got;
    if (got[7]) stall_e_count++;
    checkOutput(tag, 32'(got), 32'(exp_q.pop_front()));
    if ((got[8] && got[5]) || (got[7] && got[4]) || (got[6] && got[3]))
      checkOutput({tag, "_excl"}, 32'(1), 32'(0));
    @(posedge clk);
    modelAdvance(s);
  endtask

  initial begin
    stim_t s;
    $display("[TB] pipeline_ctrl bench start");

    // Reset with busy-looking inputs: flushes only
    s = idleStim(); s.rst = 1; s.start = 1; s.exc = 1; s.dstall = 1; s.istall = 1;
    applyStimulus("reset_0", s);
    applyStimulus("reset_1", s);
    checkOutput("reset_flushes", 32'(last_out), 32'(10'b0000111100));

    s = idleStim();
    applyStimulus("idle", s);

    // Load-use through rs, then with $zero destination
    s = idleStim(); s.memread = 1; s.wreg = 8; s.rs = 8; s.urs = 1;
    applyStimulus("load_use_rs", s);
    checkOutput("load_use_rs_vec", 32'(last_out), 32'(10'b1100010000));
    s.wreg = 0; s.rs = 0;
    applyStimulus("load_use_zero", s);
    checkOutput("load_use_zero_vec", 32'(last_out), 32'(0));

    // rt match, and rt match without the read flag
    s = idleStim(); s.memread = 1; s.wreg = 5; s.rt = 5; s.urt = 1;
    applyStimulus("load_use_rt", s);
    s.urt = 0;
    applyStimulus("rt_unused", s);

    // Fetch wait alone, and hidden by load-use
    s = idleStim(); s.istall = 1;
    applyStimulus("istall", s);
    s.memread = 1; s.wreg = 3; s.rs = 3; s.urs = 1;
    applyStimulus("istall_load_use", s);

    // Data-memory wait beats load-use and fetch wait
    s.dstall = 1;
    applyStimulus("dstall_top", s);
    checkOutput("dstall_top_vec", 32'(last_out), 32'(10'b1111000100));

    // Divide held: 32 stall cycles then one DONE cycle
    s = idleStim(); s.start = 1; s.div = 1;
    stall_e_count = 0;
    for (int i = 0; i < DIV_N; i++) applyStimulus("div", s);
    checkOutput("div_stall_count", 32'(stall_e_count), 32'(DIV_N));
    applyStimulus("div_done", s);
    checkOutput("div_done_stall_e", 32'(last_out[7]), 32'(0));
    checkOutput("div_done_busy", 32'(last_out[0]), 32'(1));
    s = idleStim();
    applyStimulus("div_after", s);

    // Divide with four data-memory wait cycles: 36 stall cycles
    stall_e_count = 0;
    for (int i = 0; i < DIV_N + 5; i++) begin
      s = idleStim(); s.start = 1; s.div = 1;
      s.dstall = (i >= 10 && i < 14);
      applyStimulus("div_dstall", s);
    end
    checkOutput("div_dstall_count", 32'(stall_e_count), 32'(DIV_N + 4));
    checkOutput("div_dstall_done", 32'(last_out[7]), 32'(0));
    s = idleStim();
    applyStimulus("div_dstall_after", s);

    // Multiply aborted by exception on its fifth cycle
    for (int i = 0; i < 5; i++) begin
      s = idleStim(); s.start = 1;
      s.dstall = (i == 1 || i == 2);
      s.exc = (i == 4);
      s.memread = 1; s.wreg = 2; s.rs = 2; s.urs = 1; s.istall = 1;
      applyStimulus("mul_exc", s);
    end
    checkOutput("mul_exc_vec", 32'(last_out), 32'(10'b0000111011));
    s = idleStim();
    applyStimulus("mul_exc_after", s);
    checkOutput("mul_exc_busy", 32'(last_out[0]), 32'(0));

    // Reset landing in the middle of a divide
    s = idleStim(); s.start = 1; s.div = 1;
    for (int i = 0; i < 5; i++) applyStimulus("div_pre_reset", s);
    s.rst = 1;
    applyStimulus("div_reset_0", s);
    applyStimulus("div_reset_1", s);
    checkOutput("div_reset_vec", 32'(last_out), 32'(10'b0000111100));
    s = idleStim();
    applyStimulus("div_reset_after", s);
    checkOutput("div_reset_busy", 32'(last_out[0]), 32'(0));

    // Random mix to exercise priority interactions
    for (int i = 0; i < 300; i++) begin
      s = idleStim();
      s.rst     = ($urandom_range(0, 59) == 0);
      s.istall  = ($urandom_range(0, 3) == 0);
      s.dstall  = ($urandom_range(0, 6) == 0);
      s.exc     = ($urandom_range(0, 24) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.urs     = 1'($urandom_range(0, 1));
      s.urt     = 1'($urandom_range(0, 1));
      s.memread = 1'($urandom_range(0, 1));
      s.wreg    = 5'($urandom_range(0, 3));
      s.start   = ($urandom_range(0, 4) == 0);
      s.div     = ($urandom_range(0, 7) == 0);
      applyStimulus("random", s);
    end

    checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 3, E-stage stall length of a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, E-stage stall length of a divide.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_stall_req  in  1  fetch memory not ready for F-stage PC.
REQ-006 SHALL have port d_stall_req  in  1  data memory not ready for M-stage access.
REQ-007 SHALL have ports d_rs, d_rt  in  5 each  source registers of the D-stage instruction.
REQ-008 SHALL have ports d_uses_rs, d_uses_rt  in  1 each  D-stage instruction reads rs / rt.
REQ-009 SHALL have port e_memread  in  1  E-stage instruction is a load.
REQ-010 SHALL have port e_wreg  in  5  E-stage destination register.
REQ-011 SHALL have port e_mdu_start  in  1  E-stage instruction is mult/div; held while it sits in E.
REQ-012 SHALL have port e_mdu_div  in  1  1 = divide, 0 = multiply; valid with e_mdu_start.
REQ-013 SHALL have port m_exception  in  1  M-stage instruction raised an exception.
REQ-014 SHALL have ports stall_f, stall_d, stall_e, stall_m  out  1 each  hold the F/D/E/M pipeline register.
REQ-015 SHALL have ports flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into D/E/M/W register.
REQ-016 SHALL have ports redirect_valid  out  1  fetch must jump to exception vector next edge; mdu_busy  out  1  MDU FSM not IDLE.

Function
REQ-017 SHALL hold an MDU FSM with states IDLE, BUSY, DONE and a 6-bit down-counter; outputs otherwise combinational.
REQ-018 SHALL define mdu_hold = (IDLE and e_mdu_start) or BUSY.
REQ-019 SHALL define load_use = e_memread and e_wreg != 0 and ((d_uses_rs and d_rs == e_wreg) or (d_uses_rt and d_rt == e_wreg)).
REQ-020 SHALL apply priority, highest first: m_exception, d_stall_req, mdu_hold, load_use, i_stall_req.
REQ-021 SHALL on m_exception: flush_d = flush_e = flush_m = 1, redirect_valid = 1, all stalls 0, regardless of other inputs.
REQ-022 SHALL on d_stall_req (no exception): stall_f/d/e/m = 1, flush_w = 1.
REQ-023 SHALL on mdu_hold (no higher cause): stall_f/d/e = 1, flush_m = 1.
REQ-024 SHALL on load_use (no higher cause): stall_f/d = 1, flush_e = 1.
REQ-025 SHALL on i_stall_req alone: stall_f = 1, flush_d = 1.
REQ-026 SHALL drive every output not named by the active cause to 0; no cause -> all outputs 0.
REQ-027 SHALL in IDLE with e_mdu_start, no m_exception and no d_stall_req: load counter with (e_mdu_div ? DIV_CYCLES : MULT_CYCLES) - 2 and enter BUSY.
REQ-028 SHALL in BUSY decrement the counter each cycle not frozen by d_stall_req; at counter == 0, enter DONE instead of decrementing.
REQ-029 SHALL make an MDU op stall E for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), the start cycle included, when no d_stall_req intervenes.
REQ-030 SHALL in DONE ignore e_mdu_start, keep mdu_hold 0, and return to IDLE on the first cycle without d_stall_req, so that the same instruction never re-triggers.
REQ-031 SHALL abort any MDU op on m_exception: next state IDLE, counter 0.
REQ-032 SHALL treat load_use and i_stall_req in the same cycle as load_use only: no flush_d.
REQ-033 SHALL keep stall and flush for the same register mutually exclusive in every cycle.
REQ-034 SHALL drive mdu_busy = 1 in BUSY or DONE, else 0.

Reset
REQ-035 SHALL while reset is high force MDU state IDLE and counter 0 on the clock edge.
REQ-036 SHALL while reset is high drive flush_d/e/m/w = 1 and all other outputs 0, regardless of inputs.
REQ-037 SHALL, when reset asserts mid-MDU-op, leave no residual BUSY/DONE state after the reset edge.

Verification
REQ-038 SHALL check: e_mdu_start = 1, e_mdu_div = 1 held -> stall_e = 1 for exactly 32 cycles, flush_m = 1 alongside, then one DONE cycle with stall_e = 0.
REQ-039 SHALL check: e_memread = 1, e_wreg = 8, d_rs = 8, d_uses_rs = 1 -> stall_f = stall_d = flush_e = 1, stall_e = 0; e_wreg = 0 instead -> all outputs 0.
REQ-040 SHALL check: d_stall_req = 1 with load_use and i_stall_req also high -> stall_f/d/e/m = 1, flush_w = 1, flush_e = flush_d = 0.
REQ-041 SHALL check: m_exception = 1 on cycle 5 of a MULT_CYCLES = 3 multiply -> flush_d/e/m = 1, redirect_valid = 1 that cycle, mdu_busy = 0 next cycle.
REQ-042 SHALL check: d_stall_req = 1 for 4 cycles during a divide -> counter frozen, total stall_e cycles = 36.
REQ-043 SHALL check: reset asserted in BUSY -> on the next cycle mdu_busy = 0 and flush_d/e/m/w = 1 while reset stays high.
